// File: rtl/dac_debug_pkg.sv
// Shared types and constants for the AD5662 SPI loopback monitor.
// FSM encoding, default frame length and DAC midscale code.
package dac_debug_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam int          FRAME_BITS_DEF = 24;
    localparam logic [15:0] MIDSCALE       = 16'h8000;
    localparam logic [4:0]  CNT_MAX        = 5'd31;

endpackage

// File: rtl/dac_spi_monitor_if.sv
// AD5662 serial pins as seen by a transmitter (master) and the monitor (slave).
// The bus is purely combinational wiring, no clock inside.
interface dac_spi_monitor_if;

    logic DAC_SYNC;
    logic DAC_SCLK;
    logic DAC_DIN;

    modport master (
        output DAC_SYNC,
        output DAC_SCLK,
        output DAC_DIN
    );

    modport slave (
        input DAC_SYNC,
        input DAC_SCLK,
        input DAC_DIN
    );

endinterface

// File: rtl/sync_edge_detect.sv
// Optional synchronizer chain followed by a one-flop edge detector.
// RST_VAL sets the idle level so no edge is reported after reset.
module sync_edge_detect #(
    parameter int STAGES  = 2,
    parameter bit RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic s,
    output logic rise,
    output logic fall
);

    logic prev;

    generate
        if (STAGES == 0) begin : g_direct
            assign s = d;
        end else begin : g_sync
            logic [STAGES-1:0] chain;
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    chain <= {STAGES{RST_VAL}};
                end else begin
                    chain[0] <= d;
                    for (int i = 1; i < STAGES; i++) begin
                        chain[i] <= chain[i-1];
                    end
                end
            end
            assign s = chain[STAGES-1];
        end
    endgenerate

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) prev <= RST_VAL;
        else        prev <= s;
    end

    assign rise = s & ~prev;
    assign fall = ~s & prev;

endmodule

// File: rtl/dac_spi_monitor.sv
// Passive monitor that decodes AD5662 frames from the DAC SPI pins,
// reports valid/malformed frames and optionally compares the data word.
module dac_spi_monitor
    import dac_debug_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FRAME_BITS  = FRAME_BITS_DEF
) (
    input  logic                  dataclk,
    input  logic                  reset,
    dac_spi_monitor_if.slave      spi,
    input  logic [15:0]           expected_word,
    input  logic                  compare_en,
    output logic [15:0]           DAC_word,
    output logic [1:0]            pd_mode,
    output logic                  word_valid,
    output logic                  frame_err,
    output logic                  mismatch,
    output logic [15:0]           frame_count,
    output logic [7:0]            err_count
);

    localparam logic [4:0] FB   = 5'(FRAME_BITS);
    localparam logic [1:0] WARM = 2'(SYNC_STAGES);

    logic sync_s, sync_rise, sync_fall;
    logic sclk_fall, din_s;
    logic unused_sclk_s, unused_sclk_rise;
    logic unused_din_rise, unused_din_fall;

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
        .clk(dataclk), .reset(reset), .d(spi.DAC_SYNC),
        .s(sync_s), .rise(sync_rise), .fall(sync_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
        .clk(dataclk), .reset(reset), .d(spi.DAC_SCLK),
        .s(unused_sclk_s), .rise(unused_sclk_rise), .fall(sclk_fall)
    );

    sync_edge_detect #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_din (
        .clk(dataclk), .reset(reset), .d(spi.DAC_DIN),
        .s(din_s), .rise(unused_din_rise), .fall(unused_din_fall)
    );

    state_t      state;
    logic [23:0] shift;
    logic [4:0]  cnt;
    logic [1:0]  warm;
    logic        armed;
    logic        unused_hi;

    assign unused_hi = ^shift[23:18];

    // A frame may only start once SYNC has been seen high from the pins,
    // so a reset released mid-frame skips the remainder of that frame.
    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            warm  <= '0;
            armed <= 1'b0;
        end else begin
            if (warm != WARM) warm <= warm + 2'd1;
            armed <= armed | ((warm == WARM) & sync_s);
        end
    end

    always_ff @(posedge dataclk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            shift       <= '0;
            cnt         <= '0;
            DAC_word    <= '0;
            pd_mode     <= '0;
            word_valid  <= 1'b0;
            frame_err   <= 1'b0;
            mismatch    <= 1'b0;
            frame_count <= '0;
            err_count   <= '0;
        end else begin
            word_valid <= 1'b0;
            frame_err  <= 1'b0;
            mismatch   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (sync_fall && armed) begin
                        state <= SHIFT;
                        shift <= '0;
                        cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (sync_rise) begin
                        state <= FLUSH;
                    end else if (sclk_fall && !sync_s) begin
                        shift <= {shift[22:0], din_s};
                        if (cnt != CNT_MAX) cnt <= cnt + 5'd1;
                    end
                end
                FLUSH: begin
                    state <= IDLE;
                    if (cnt == FB) begin
                        DAC_word    <= shift[15:0];
                        pd_mode     <= shift[17:16];
                        word_valid  <= 1'b1;
                        mismatch    <= compare_en &
                                       (shift[15:0] != expected_word);
                        frame_count <= frame_count + 16'd1;
                    end else begin
                        frame_err <= 1'b1;
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dac_spi_monitor.sv
// Random and directed AD5662 frames checked every cycle against a
// frame-level model of the monitor outputs.
module tb_dac_spi_monitor;
    import dac_debug_pkg::*;

    localparam int SS  = 2;
    localparam int LAT = SS + 2;
    localparam int H   = 2;

    logic        dataclk = 1'b0;
    logic        reset   = 1'b0;
    logic [15:0] expected_word = '0;
    logic        compare_en = 1'b0;
    logic [15:0] DAC_word;
    logic [1:0]  pd_mode;
    logic        word_valid, frame_err, mismatch;
    logic [15:0] frame_count;
    logic [7:0]  err_count;

    dac_spi_monitor_if spi();

    dac_spi_monitor #(.SYNC_STAGES(SS), .FRAME_BITS(FRAME_BITS_DEF)) dut (
        .dataclk(dataclk), .reset(reset), .spi(spi),
        .expected_word(expected_word), .compare_en(compare_en),
        .DAC_word(DAC_word), .pd_mode(pd_mode),
        .word_valid(word_valid), .frame_err(frame_err),
        .mismatch(mismatch), .frame_count(frame_count),
        .err_count(err_count)
    );

    always #5 dataclk = ~dataclk;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int both_seen = 0;

    typedef struct {
        int          due;
        bit          ok;
        logic [15:0] w;
        logic [1:0]  pd;
        bit          mm;
    } ev_t;
    ev_t q[$];

    logic [15:0] m_word = '0;
    logic [1:0]  m_pd   = '0;
    logic [15:0] m_fc   = '0;
    logic [7:0]  m_ec   = '0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    always @(posedge dataclk) cyc++;

    // Frame-level model: each finished frame yields one event due LAT
    // cycles after SYNC rises at the pins.
    always @(negedge dataclk) begin
        bit ev_v, ev_e, ev_m;
        ev_t ev;
        ev_v = 0; ev_e = 0; ev_m = 0;
        if (reset && q.size() > 0 && q[0].due == cyc) begin
            ev = q.pop_front();
            if (ev.ok) begin
                ev_v   = 1;
                ev_m   = ev.mm;
                m_word = ev.w;
                m_pd   = ev.pd;
                m_fc   = m_fc + 16'd1;
            end else begin
                ev_e = 1;
                if (m_ec != 8'hFF) m_ec = m_ec + 8'd1;
            end
        end
        if (word_valid && mismatch) both_seen++;
        chk("word_valid", 32'(word_valid), 32'(ev_v));
        chk("frame_err", 32'(frame_err), 32'(ev_e));
        chk("mismatch", 32'(mismatch), 32'(ev_m));
        chk("DAC_word", 32'(DAC_word), 32'(m_word));
        chk("pd_mode", 32'(pd_mode), 32'(m_pd));
        chk("frame_count", 32'(frame_count), 32'(m_fc));
        chk("err_count", 32'(err_count), 32'(m_ec));
    end

    task automatic step(input int k);
        repeat (k) @(negedge dataclk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        q.delete();
        m_word = '0; m_pd = '0; m_fc = '0; m_ec = '0;
        step(3);
        reset = 1'b1;
    endtask

    task automatic send_frame(input int n, input logic [39:0] bits,
                              input bit c_start, input bit c_end,
                              input int rst_at);
        bit   abort;
        ev_t  ev;
        abort = 0;
        if (c_start) begin
            spi.DAC_SCLK = 1'b1;
            step(H);
            spi.DAC_SYNC = 1'b0;
            spi.DAC_SCLK = 1'b0;
        end else begin
            spi.DAC_SYNC = 1'b0;
        end
        step(H);
        for (int i = n - 1; i >= 0; i--) begin
            spi.DAC_SCLK = 1'b1;
            spi.DAC_DIN  = 1'($urandom);
            step(1);
            spi.DAC_DIN  = bits[i];
            step(H);
            spi.DAC_SCLK = 1'b0;
            step(H);
            if (n - i == rst_at) begin
                do_reset();
                abort = 1;
            end
        end
        if (c_end) begin
            spi.DAC_SCLK = 1'b1;
            step(H);
            spi.DAC_SYNC = 1'b1;
            spi.DAC_SCLK = 1'b0;
        end else begin
            spi.DAC_SYNC = 1'b1;
        end
        if (!abort) begin
            ev.due = cyc + LAT;
            ev.ok  = (n == FRAME_BITS_DEF);
            ev.w   = bits[15:0];
            ev.pd  = bits[17:16];
            ev.mm  = ev.ok && compare_en && (bits[15:0] != expected_word);
            q.push_back(ev);
        end
        step(LAT + 4);
    endtask

    initial begin
        logic [39:0] b;
        int          n;
        spi.DAC_SYNC = 1'b1;
        spi.DAC_SCLK = 1'b0;
        spi.DAC_DIN  = 1'b0;
        step(3);
        reset = 1'b1;
        step(5);
        chk("reset DAC_word", 32'(DAC_word), 32'h0);
        chk("reset frame_count", 32'(frame_count), 32'h0);

        send_frame(24, {16'h0, 8'h00, 16'hA5C3}, 0, 0, -1);
        chk("loopback DAC_word", 32'(DAC_word), 32'hA5C3);
        chk("loopback pd_mode", 32'(pd_mode), 32'h0);
        chk("loopback frame_count", 32'(frame_count), 32'h1);

        send_frame(24, {16'h0, 8'hEB, 16'h0001}, 0, 0, -1);
        chk("pd11 pd_mode", 32'(pd_mode), 32'h3);
        chk("pd11 DAC_word", 32'(DAC_word), 32'h0001);

        send_frame(20, 40'hF_FFFF, 0, 0, -1);
        chk("short err_count", 32'(err_count), 32'h1);
        chk("short DAC_word", 32'(DAC_word), 32'h0001);

        send_frame(30, 40'h12_3456_789A, 0, 0, -1);
        chk("overrun err_count", 32'(err_count), 32'h2);

        compare_en    = 1'b1;
        expected_word = MIDSCALE;
        send_frame(24, {16'h0, 8'h00, 16'h8001}, 0, 0, -1);
        send_frame(24, {16'h0, 8'h00, 16'h8000}, 0, 0, -1);
        chk("mismatch pulses", 32'(both_seen), 32'h1);
        compare_en = 1'b0;

        send_frame(24, {16'h0, 8'h01, 16'h5A5A}, 1, 0, -1);
        send_frame(24, {16'h0, 8'h02, 16'h0F0F}, 0, 1, -1);
        chk("coincident DAC_word", 32'(DAC_word), 32'h0F0F);

        send_frame(24, {16'h0, 8'h00, 16'h7777}, 0, 0, 10);
        chk("post-reset err_count", 32'(err_count), 32'h0);
        chk("post-reset frame_count", 32'(frame_count), 32'h0);
        send_frame(24, {16'h0, 8'h00, 16'h1234}, 0, 0, -1);
        chk("resume DAC_word", 32'(DAC_word), 32'h1234);
        chk("resume frame_count", 32'(frame_count), 32'h1);

        for (int k = 0; k < 40; k++) begin
            b = {8'($urandom), 32'($urandom)};
            n = ($urandom_range(0, 9) < 7) ? 24 : int'($urandom_range(1, 35));
            compare_en    = 1'($urandom);
            expected_word = $urandom_range(0, 1) ? 16'($urandom) : b[15:0];
            send_frame(n, b, 1'($urandom), 1'($urandom), -1);
        end
        compare_en = 1'b0;

        for (int k = 0; k < 300; k++) begin
            send_frame(int'($urandom_range(1, 5)), 40'h0, 0, 0, -1);
        end
        chk("saturated err_count", 32'(err_count), 32'hFF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
